axil_master: RTL and testbench

- AXI4-Lite initiator that issues single read/write transactions, one at a time, into register slaves such as the accelerator's control/status register block (address bits [11:2], run/matw/last at 0x00, control at 0x10).
- Sits in the host-side control path and in simulation benches.
- Converts a simple valid/ready command port into fully compliant AW/W/B and AR/R handshakes.
- Returns response code and read data on a one-cycle response pulse, and flags slaves that never respond.

---
 rtl/axil_master.sv | 214 +++++++++++++++++++++
 tb/tb_axil_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master.sv
// rtl/axil_master.sv - AXI4-Lite initiator issuing one read or write at a time
//
// Purpose:
//   Turns a valid/ready command port into single AXI4-Lite transactions.
//   Reports completion with a one-cycle rsp_valid pulse that carries the
//   response code and the read data.
//   A watchdog sets the sticky hang flag when a slave stalls for TIMEOUT cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cmd_*             command request (valid/ready, write, addr, wdata)
//   rsp_*             completion pulse, response code, read data
//   hang              sticky watchdog flag
//   M_AXI_AW*/W*/B*   AXI4-Lite write channels
//   M_AXI_AR*/R*      AXI4-Lite read channels

module axil_master #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   output logic [1:0]        rsp_resp,
   output logic [31:0]       rsp_rdata,
   output logic              hang,
   output logic [ADDR_W-1:0] M_AXI_AWADDR,
   output logic              M_AXI_AWVALID,
   input  logic              M_AXI_AWREADY,
   output logic [31:0]       M_AXI_WDATA,
   output logic [3:0]        M_AXI_WSTRB,
   output logic              M_AXI_WVALID,
   input  logic              M_AXI_WREADY,
   input  logic [1:0]        M_AXI_BRESP,
   input  logic              M_AXI_BVALID,
   output logic              M_AXI_BREADY,
   output logic [ADDR_W-1:0] M_AXI_ARADDR,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   input  logic [31:0]       M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY
);

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

   localparam int               CNT_W     = (TIMEOUT > 65535) ? 32 : 16;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t            state_q;
   logic              aw_done_q, w_done_q;
   logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic [ADDR_W-1:0] awaddr_q, araddr_q;
   logic [31:0]       wdata_q;
   logic              rsp_valid_q;
   logic [1:0]        rsp_resp_q;
   logic [31:0]       rsp_rdata_q;
   logic              hang_q;
   logic [CNT_W-1:0]  wdog_q, wdog_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_both, leaving;

   // The VALID/READY flops are only ever high in their own state, so an
   // early BVALID or RVALID cannot produce a handshake before its state.
   assign aw_hs = awvalid_q & M_AXI_AWREADY;
   assign w_hs  = wvalid_q  & M_AXI_WREADY;
   assign b_hs  = bready_q  & M_AXI_BVALID;
   assign ar_hs = arvalid_q & M_AXI_ARREADY;
   assign r_hs  = rready_q  & M_AXI_RVALID;

   // Address and data phases finish independently, possibly on the same edge.
   assign wr_both = (aw_done_q | aw_hs) & (w_done_q | w_hs);

   always_comb begin
      leaving = 1'b0;
      case (state_q)
         WRITE:   leaving = wr_both;
         WRESP:   leaving = b_hs;
         RADDR:   leaving = ar_hs;
         RDATA:   leaving = r_hs;
         default: leaving = 1'b0;
      endcase
   end

   // The watchdog measures how long the FSM has stayed in one wait state.
   // It restarts on every state change and saturates, so it cannot wrap.
   always_comb begin
      if (state_q == IDLE || leaving) begin
         wdog_d = '0;
      end else if (&wdog_q) begin
         wdog_d = wdog_q;
      end else begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_resp_q  <= 2'b00;
         rsp_rdata_q <= '0;
         hang_q      <= 1'b0;
         wdog_q      <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         wdog_q      <= wdog_d;
         // hang is raised on the edge where the counter reaches TIMEOUT.
         // The transaction itself keeps waiting.
         if (TIMEOUT != 0 && wdog_d == TIMEOUT_C) begin
            hang_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_write) begin
                     awaddr_q  <= cmd_addr;
                     wdata_q   <= cmd_wdata;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done_q <= 1'b0;
                     w_done_q  <= 1'b0;
                     state_q   <= WRITE;
                  end else begin
                     araddr_q  <= cmd_addr;
                     arvalid_q <= 1'b1;
                     state_q   <= RADDR;
                  end
               end
            end

            WRITE: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if (wr_both) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  state_q   <= WRESP;
               end
            end

            WRESP: begin
               if (b_hs) begin
                  bready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_resp_q  <= M_AXI_BRESP;
                  rsp_rdata_q <= '0;
                  state_q     <= IDLE;
               end
            end

            RADDR: begin
               if (ar_hs) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RDATA;
               end
            end

            RDATA: begin
               if (r_hs) begin
                  rready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_resp_q  <= M_AXI_RRESP;
                  rsp_rdata_q <= M_AXI_RDATA;
                  state_q     <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready     = (state_q == IDLE);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign hang          = hang_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = 4'hf;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// tb/tb_axil_master.sv - self-checking bench for axil_master

module tb_axil_master;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic        cmd_ready, rsp_valid, hang;
   logic [1:0]  rsp_resp;
   logic [31:0] rsp_rdata;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bready, arvalid, arready, rready;
   logic        s_bvalid, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;

   always #5 clk = ~clk;

   axil_master #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .hang(hang),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(rready)
   );

   // Register slave: it captures AW and W, stores the data, then answers with B
   // on the following cycle. Read data follows the AR handshake after r_delay.
   int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
   bit          ar_never = 0, b_hold = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   int          aw_wait, w_wait, ar_wait, r_wait;
   bit          got_aw, got_w, got_ar;
   logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
   logic [31:0] mem [0:1023];
   int          b_cnt = 0;

   assign awready = awvalid && (aw_wait >= aw_delay);
   assign wready  = wvalid  && (w_wait  >= w_delay);
   assign arready = arvalid && !ar_never && (ar_wait >= ar_delay);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0;
         got_aw <= 0; got_w <= 0; got_ar <= 0;
         s_bvalid <= 0; s_rvalid <= 0; s_bresp <= 0; s_rresp <= 0; s_rdata <= 0;
      end else begin
         aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
         w_wait  <= (wvalid  && !wready)  ? w_wait + 1  : 0;
         ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
         if (awvalid && awready) begin got_aw <= 1; aw_addr_s <= awaddr; end
         if (wvalid && wready) begin got_w <= 1; w_data_s <= wdata; end
         if (got_aw && got_w && !s_bvalid && !b_hold) begin
            mem[aw_addr_s[11:2]] <= w_data_s;
            s_bvalid <= 1; s_bresp <= bresp_cfg;
            got_aw <= 0; got_w <= 0;
         end
         if (s_bvalid && bready) begin s_bvalid <= 0; b_cnt <= b_cnt + 1; end
         if (arvalid && arready) begin got_ar <= 1; ar_addr_s <= araddr; r_wait <= 0; end
         if (got_ar && !s_rvalid) begin
            if (r_wait >= r_delay) begin
               s_rvalid <= 1; s_rdata <= mem[ar_addr_s[11:2]]; s_rresp <= rresp_cfg;
               got_ar <= 0;
            end else begin
               r_wait <= r_wait + 1;
            end
         end
         if (s_rvalid && rready) s_rvalid <= 0;
      end
   end

   typedef struct { logic [1:0] resp; logic [31:0] rdata; } exp_t;
   exp_t        sb [$];
   logic [31:0] model [0:1023];
   int          total = 0, bad = 0;

   task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      total++;
      if (!cmd_ready) begin bad++; $display("FAIL cmd_accept: cmd_ready=%0b want 1", cmd_ready); end
      @(posedge clk);
      #1 cmd_valid = 0;
   endtask

   task automatic wait_rsp(input int max, output bit got, output int lat,
                           output logic [1:0] resp, output logic [31:0] rdata);
      got = 0; lat = 0; resp = 'x; rdata = 'x;
      while (!got && lat < max) begin
         @(negedge clk); lat++;
         if (rsp_valid) begin got = 1; resp = rsp_resp; rdata = rsp_rdata; end
      end
   endtask

   task automatic test_reset();
      rst = 1;
      #1;
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, hang} !== 7'b0) begin
         bad++; $display("FAIL reset_valids: got %b want 0", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, hang});
      end
      total++;
      if ({rsp_resp, rsp_rdata, awaddr, araddr, wdata} !== '0) begin
         bad++; $display("FAIL reset_regs: resp=%h rdata=%h awaddr=%h araddr=%h wdata=%h want 0",
                         rsp_resp, rsp_rdata, awaddr, araddr, wdata);
      end
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_write();
      bit aw_s[1:8], w_s[1:8], br_s[1:8], rv_s[1:8], cr_s[1:8];
      logic [1:0] resp_s; logic [31:0] rdata_s; logic [31:0] addr1, data1; logic [3:0] strb1;
      int ridx = 0; exp_t e;
      sb.push_back('{2'b00, 32'h0}); model[4] = 32'hDEADBEEF;
      issue_cmd(1, 32'h10, 32'hDEADBEEF);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         aw_s[k] = awvalid; w_s[k] = wvalid; br_s[k] = bready; rv_s[k] = rsp_valid; cr_s[k] = cmd_ready;
         if (k == 1) begin addr1 = awaddr; data1 = wdata; strb1 = wstrb; end
         if (rsp_valid && ridx == 0) begin ridx = k; resp_s = rsp_resp; rdata_s = rsp_rdata; end
      end
      total++;
      if (!(aw_s[1] && w_s[1] && addr1 == 32'h10 && data1 == 32'hDEADBEEF && strb1 == 4'hf)) begin
         bad++; $display("FAIL wr_first_cycle: aw=%b w=%b addr=%h data=%h strb=%h want 1 1 10 deadbeef f",
                         aw_s[1], w_s[1], addr1, data1, strb1);
      end
      total++;
      if ({aw_s[2], w_s[2], br_s[2]} !== 3'b001) begin
         bad++; $display("FAIL wr_bready: aw/w/bready=%b want 001", {aw_s[2], w_s[2], br_s[2]});
      end
      total++;
      if (ridx !== 4) begin bad++; $display("FAIL wr_latency: rsp cycle %0d want 4", ridx); end
      if (ridx != 0) begin
         e = sb.pop_front();
         total++;
         if (resp_s !== e.resp || rdata_s !== e.rdata) begin
            bad++; $display("FAIL wr_rsp: resp=%b rdata=%h want %b %h", resp_s, rdata_s, e.resp, e.rdata);
         end
         total++;
         if (cr_s[ridx] !== 1'b1 || (ridx < 8 && rv_s[ridx+1] !== 1'b0)) begin
            bad++; $display("FAIL wr_pulse: cmd_ready=%b next_rsp=%b want 1 0", cr_s[ridx], rv_s[ridx < 8 ? ridx+1 : 8]);
         end
      end
      total++;
      if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_slave_reg: got %h want deadbeef", mem[4]); end
   endtask

   task automatic test_aw_late();
      int aw_hi = 0, w_hi = 0, addr_bad = 0, n = 0, b0; bit got = 0;
      logic [1:0] resp_s; logic [31:0] rdata_s; exp_t e;
      aw_delay = 3; w_delay = 0; bresp_cfg = 2'b01; b0 = b_cnt;
      sb.push_back('{2'b01, 32'h0}); model[0] = 32'h2;
      issue_cmd(1, 32'h00, 32'h2);
      while (!got && n < 30) begin
         @(negedge clk); n++;
         if (awvalid) begin aw_hi++; if (awaddr !== 32'h0) addr_bad++; end
         if (wvalid) w_hi++;
         if (rsp_valid) begin got = 1; resp_s = rsp_resp; rdata_s = rsp_rdata; end
      end
      @(negedge clk);
      total++;
      if (aw_hi != 4 || w_hi != 1 || addr_bad != 0) begin
         bad++; $display("FAIL awlate_valids: aw_cycles=%0d w_cycles=%0d addr_bad=%0d want 4 1 0", aw_hi, w_hi, addr_bad);
      end
      total++;
      if (b_cnt - b0 != 1) begin bad++; $display("FAIL awlate_bcount: got %0d want 1", b_cnt - b0); end
      total++;
      if (!got) begin
         bad++; $display("FAIL awlate_rsp: no response want one");
      end else begin
         e = sb.pop_front();
         if (resp_s !== e.resp || rdata_s !== e.rdata) begin
            bad++; $display("FAIL awlate_rsp: resp=%b rdata=%h want %b %h", resp_s, rdata_s, e.resp, e.rdata);
         end
      end
      aw_delay = 0; bresp_cfg = 2'b00;
   endtask

   task automatic test_readback();
      bit got; int lat; logic [1:0] resp_s; logic [31:0] rdata_s; exp_t e;
      r_delay = 5;
      sb.push_back('{2'b00, model[4]});
      issue_cmd(0, 32'h10, 32'h0);
      wait_rsp(40, got, lat, resp_s, rdata_s);
      total++;
      if (!got || lat != 9) begin bad++; $display("FAIL rd_delay_latency: got=%b cycle=%0d want 1 9", got, lat); end
      if (got) begin
         e = sb.pop_front();
         total++;
         if (resp_s !== e.resp || rdata_s !== e.rdata) begin
            bad++; $display("FAIL rd_delay_rsp: resp=%b rdata=%h want %b %h", resp_s, rdata_s, e.resp, e.rdata);
         end
         total++;
         if (rready !== 1'b0) begin bad++; $display("FAIL rd_rready_drop: got %b want 0", rready); end
      end
      r_delay = 0;
      sb.push_back('{2'b00, model[0]});
      issue_cmd(0, 32'h00, 32'h0);
      wait_rsp(20, got, lat, resp_s, rdata_s);
      total++;
      if (!got) begin
         bad++; $display("FAIL rd_run_rsp: no response want one");
      end else begin
         e = sb.pop_front();
         if (resp_s !== e.resp || rdata_s !== e.rdata || lat != 4) begin
            bad++; $display("FAIL rd_run_rsp: resp=%b rdata=%h cycle=%0d want %b %h 4", resp_s, rdata_s, lat, e.resp, e.rdata);
         end
      end
   endtask

   task automatic test_error();
      bit got; int lat; logic [1:0] resp_s; logic [31:0] rdata_s; exp_t e;
      bresp_cfg = 2'b10;
      sb.push_back('{2'b10, 32'h0}); model[8] = 32'h55;
      issue_cmd(1, 32'h20, 32'h55);
      wait_rsp(20, got, lat, resp_s, rdata_s);
      total++;
      if (!got) begin
         bad++; $display("FAIL err_write: no response want one");
      end else begin
         e = sb.pop_front();
         if (resp_s !== e.resp || rdata_s !== e.rdata) begin
            bad++; $display("FAIL err_write: resp=%b rdata=%h want %b %h", resp_s, rdata_s, e.resp, e.rdata);
         end
      end
      bresp_cfg = 2'b00; rresp_cfg = 2'b11;
      sb.push_back('{2'b11, model[8]});
      issue_cmd(0, 32'h20, 32'h0);
      wait_rsp(20, got, lat, resp_s, rdata_s);
      total++;
      if (!got) begin
         bad++; $display("FAIL err_read: no response want one");
      end else begin
         e = sb.pop_front();
         if (resp_s !== e.resp || rdata_s !== e.rdata) begin
            bad++; $display("FAIL err_read: resp=%b rdata=%h want %b %h", resp_s, rdata_s, e.resp, e.rdata);
         end
      end
      rresp_cfg = 2'b00;
   endtask

   task automatic test_hang();
      bit got, rv_seen = 0, h8 = 0, h9 = 0, arv9 = 0; int lat;
      logic [1:0] resp_s; logic [31:0] rdata_s; exp_t e;
      ar_never = 1;
      sb.push_back('{2'b00, model[4]});
      issue_cmd(0, 32'h10, 32'h0);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (rsp_valid) rv_seen = 1;
         if (k == 8) h8 = hang;
         if (k == 9) begin h9 = hang; arv9 = arvalid; end
      end
      total++;
      if ({h8, h9, arv9, rv_seen} !== 4'b0110) begin
         bad++; $display("FAIL hang_timing: hang8=%b hang9=%b arvalid=%b rsp=%b want 0 1 1 0", h8, h9, arv9, rv_seen);
      end
      ar_never = 0;
      wait_rsp(20, got, lat, resp_s, rdata_s);
      total++;
      if (!got) begin
         bad++; $display("FAIL hang_release: no response want one");
      end else begin
         e = sb.pop_front();
         if (resp_s !== e.resp || rdata_s !== e.rdata || hang !== 1'b1) begin
            bad++; $display("FAIL hang_release: resp=%b rdata=%h hang=%b want %b %h 1", resp_s, rdata_s, hang, e.resp, e.rdata);
         end
      end
   endtask

   task automatic test_reset_in_wresp();
      bit got; int lat, n = 0; logic [1:0] resp_s; logic [31:0] rdata_s; exp_t e;
      b_hold = 1;
      issue_cmd(1, 32'h30, 32'h1234);
      while (!bready && n < 20) begin @(negedge clk); n++; end
      total++;
      if (bready !== 1'b1) begin bad++; $display("FAIL rstw_reach_wresp: bready=%b want 1", bready); end
      #2 rst = 1;
      #1;
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, hang, rsp_resp, rsp_rdata, awaddr, wdata} !== '0
          || cmd_ready !== 1'b1) begin
         bad++; $display("FAIL rstw_async: valids=%b hang=%b awaddr=%h wdata=%h cmd_ready=%b want 0 0 0 0 1",
                         {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, hang, awaddr, wdata, cmd_ready);
      end
      @(negedge clk);
      rst = 0; b_hold = 0;
      sb.push_back('{2'b00, model[0]});
      issue_cmd(0, 32'h00, 32'h0);
      wait_rsp(20, got, lat, resp_s, rdata_s);
      total++;
      if (!got) begin
         bad++; $display("FAIL rstw_next_cmd: no response want one");
      end else begin
         e = sb.pop_front();
         if (resp_s !== e.resp || rdata_s !== e.rdata || hang !== 1'b0) begin
            bad++; $display("FAIL rstw_next_cmd: resp=%b rdata=%h hang=%b want %b %h 0", resp_s, rdata_s, hang, e.resp, e.rdata);
         end
      end
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL sb_empty: %0d left want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_aw_late();
      test_readback();
      test_error();
      test_hang();
      test_reset_in_wresp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
